// File: rtl/num_display_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment display driver.
// Holds the active-low segment codes ({dp,g,f,e,d,c,b,a}), the converter
// FSM state type, the digit count and a digit-to-segment decode helper.
package num_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_0       = 8'hC0;
    localparam logic [7:0] SEG_1       = 8'hF9;
    localparam logic [7:0] SEG_2       = 8'hA4;
    localparam logic [7:0] SEG_3       = 8'hB0;
    localparam logic [7:0] SEG_4       = 8'h99;
    localparam logic [7:0] SEG_5       = 8'h92;
    localparam logic [7:0] SEG_6       = 8'h82;
    localparam logic [7:0] SEG_7       = 8'hF8;
    localparam logic [7:0] SEG_8       = 8'h80;
    localparam logic [7:0] SEG_9       = 8'h90;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    // AND mask that pulls the (active-low) decimal point on.
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble binary-to-BCD converter.
// One clock to capture, sixteen shift clocks, then one clock in DONE where
// the (saturated) BCD and the overflow flag are valid.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : capture bin and begin a conversion (honoured only when idle)
//   bin        : binary input value
//   busy       : converter is not idle
//   done       : one-cycle strobe; bcd/ovf are valid during it
//   bcd        : packed 4-digit BCD, forced to 9999 when the input was > 9999
//   ovf        : captured input exceeded 9999
module bin2bcd_seq
    import num_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    conv_state_t state_reg, state_next;
    logic [15:0] bin_reg;
    logic [15:0] bcd_work;
    logic [3:0]  cnt_reg;
    logic        big_reg;
    logic [15:0] bcd_adj;

    // Add-3 correction on every nibble that is 5 or more before each shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_work[gi*4 +: 4] >= 4'd5)
                                      ? bcd_work[gi*4 +: 4] + 4'd3
                                      : bcd_work[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_work  <= '0;
            cnt_reg   <= '0;
            big_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg  <= bin;
                        bcd_work <= '0;
                        cnt_reg  <= '0;
                        big_reg  <= (bin > 16'd9999);
                    end
                end
                SHIFT: begin
                    // Ten-thousands carry falls off the top; over-range
                    // inputs are saturated from big_reg instead.
                    bcd_work <= {bcd_adj[14:0], bin_reg[15]};
                    bin_reg  <= {bin_reg[14:0], 1'b0};
                    cnt_reg  <= cnt_reg + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign bcd  = big_reg ? 16'h9999 : bcd_work;
    assign ovf  = big_reg;

endmodule

// File: rtl/num_display_mux.sv
// 4-digit common-anode multiplexed 7-segment display driver.
// Converts a 16-bit value to BCD whenever it differs from the last converted
// value, then scans the digits with leading-zero blanking and an over-range
// decimal point indicator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   value      : unsigned binary number to display
//   led        : active-low segments {dp,g,f,e,d,c,b,a}
//   state      : active-low one-hot anode select, bit0 = ones digit
//   result     : packed BCD currently displayed
module num_display_mux
    import num_display_pkg::*;
#(
    parameter int DIV_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    output logic [7:0]  led,
    output logic [3:0]  state,
    output logic [15:0] result
);

    logic [15:0]         last_reg;
    logic [15:0]         result_reg;
    logic                ovf_reg;
    logic [DIV_BITS-1:0] presc_reg;
    logic [1:0]          idx_reg;
    logic [1:0]          idx_next;
    logic [7:0]          led_reg;
    logic [3:0]          state_reg;

    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic        conv_ovf;

    // Re-convert whenever the input differs from what was last captured;
    // a change mid-conversion is therefore picked up on the next idle cycle.
    assign conv_start = !conv_busy && (value != last_reg);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    logic [NUM_DIGITS-1:0] nib_nz;
    logic [NUM_DIGITS-1:0] blank;
    logic [7:0]            digit_seg [NUM_DIGITS];

    // A digit is blanked when it and every digit above it are zero; the
    // ones digit always shows.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_nz[gi] = |result_reg[gi*4 +: 4];
            if (gi == 0) begin : g_ones
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = ~(|nib_nz[NUM_DIGITS-1:gi]);
            end
            assign digit_seg[gi] = blank[gi] ? SEG_BLANK
                                 : (seg_decode(result_reg[gi*4 +: 4])
                                    & (ovf_reg ? SEG_DP_MASK : 8'hFF));
        end
    endgenerate

    assign idx_next = (&presc_reg) ? idx_reg + 2'd1 : idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg   <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            presc_reg  <= '0;
            idx_reg    <= '0;
            led_reg    <= SEG_0;
            state_reg  <= 4'b1110;
        end else begin
            if (conv_start) last_reg <= value;
            if (conv_done) begin
                result_reg <= conv_bcd;
                ovf_reg    <= conv_ovf;
            end
            presc_reg <= presc_reg + DIV_BITS'(1);
            idx_reg   <= idx_next;
            // Segments and anodes come from the same index on the same
            // edge so there is no ghosting skew between them.
            led_reg   <= digit_seg[idx_next];
            state_reg <= ~(4'b0001 << idx_next);
        end
    end

    assign led    = led_reg;
    assign state  = state_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_num_display_mux.sv
module tb_num_display_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'd1234;
    logic [7:0]  led;
    logic [3:0]  state;
    logic [15:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    num_display_mux #(.DIV_BITS(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .led    (led),
        .state  (state),
        .result (result)
    );

    // Segment codes for digits 0-9, active-low, dp off.
    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] ref_led(input int v, input int d);
        int p;
        if (v > 9999) return seg_tbl[9] & 8'h7F;
        p = 10 ** d;
        if (d > 0 && v < p) return 8'hFF;
        return seg_tbl[(v / p) % 10];
    endfunction

    task automatic convert(input int v, input int prev);
        @(negedge clk);
        value = 16'(v);
        repeat (17) @(posedge clk);
        #1;
        if (ref_bcd(prev) != ref_bcd(v)) check("latency_early", result, ref_bcd(prev));
        @(posedge clk);
        #1;
        check("result", result, ref_bcd(v));
        $display("conv value=%0d result=%h expected=%h", v, result, ref_bcd(v));
    endtask

    task automatic check_frame(input int v);
        int cnt [4];
        int d;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        repeat (2) @(posedge clk);
        for (int s = 0; s < 16; s++) begin
            @(posedge clk);
            #1;
            d = -1;
            for (int k = 0; k < 4; k++) if (state === ~(4'b0001 << k)) d = k;
            check("state_onehot", (d >= 0), 1);
            if (d >= 0) begin
                check("led_digit", led, ref_led(v, d));
                cnt[d]++;
            end
        end
        for (int k = 0; k < 4; k++) check("digit_period", cnt[k], 4);
        $display("frame value=%0d digits=%h %h %h %h", v,
                 ref_led(v, 3), ref_led(v, 2), ref_led(v, 1), ref_led(v, 0));
    endtask

    initial begin
        int prev;
        int v;
        int found;
        bit seen100;

        // Reset with a nonzero value present.
        #23;
        check("rst_result", result, 16'h0000);
        check("rst_state", state, 4'b1110);
        check("rst_led", led, 8'hC0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_result", result, 16'h0000);
        check("post_rst_state", state, 4'b1110);
        check("post_rst_led", led, 8'hC0);
        repeat (16) @(posedge clk);
        #1;
        check("rst_conv_early", result, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_conv", result, ref_bcd(1234));
        $display("conv value=1234 result=%h expected=%h", result, ref_bcd(1234));
        check_frame(1234);

        // Directed edge values.
        convert(100, 1234);   check_frame(100);
        convert(9999, 100);   check_frame(9999);
        convert(12345, 9999); check_frame(12345);
        convert(65535, 12345); check_frame(65535);
        convert(0, 65535);    check_frame(0);

        // Value change five clocks into a conversion.
        @(negedge clk);
        value = 16'd100;
        repeat (5) @(posedge clk);
        @(negedge clk);
        value = 16'd9999;
        found = 0;
        seen100 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (result === 16'h0100) seen100 = 1'b1;
            if (result === 16'h9999) begin
                found = k;
                break;
            end
        end
        check("restart_saw_0100", seen100, 1);
        check("restart_within_36", (found > 0 && found <= 36), 1);
        $display("restart 100->9999 result=%h after %0d clocks", result, found);
        check_frame(9999);

        // Reset in the middle of SHIFT.
        @(negedge clk);
        value = 16'd4321;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_result", result, 16'h0000);
        check("midrst_state", state, 4'b1110);
        check("midrst_led", led, 8'hC0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        check("midrst_reconv_early", result, 16'h0000);
        @(posedge clk);
        #1;
        check("midrst_reconv", result, ref_bcd(4321));
        $display("conv after reset value=4321 result=%h expected=%h", result, ref_bcd(4321));
        check_frame(4321);

        // Randomized values against the reference model.
        prev = 4321;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 65535));
            else v = int'($urandom_range(0, 9999));
            if (v == prev) v = (v + 1) % 65536;
            convert(v, prev);
            check_frame(v);
            prev = v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
